// File: rtl/keypad_emulator.sv
// Scripted 3x4 keypad: replays one accepted key code as a bounced press/hold/release
// sequence and answers the column scanner combinationally from the registered key image.
module keypad_emulator #(
    parameter int HOLD_CYCLES   = 16,
    parameter int GAP_CYCLES    = 16,
    parameter int BOUNCE_CYCLES = 4,
    parameter int CNT_W         = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  code_in,
    input  logic        code_valid,
    output logic        code_ready,
    input  logic [2:0]  Col,
    output logic [3:0]  Row,
    output logic [11:0] key_out,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE,
        BOUNCE_P,
        HOLD,
        BOUNCE_R,
        GAP
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] GAP_LD    = CNT_W'(GAP_CYCLES);
    localparam logic [CNT_W-1:0] BOUNCE_LD = CNT_W'(BOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam bit               HAS_BOUNCE = (BOUNCE_CYCLES != 0);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  timer_q, timer_d;
    logic [3:0]        code_q, code_d;
    logic [11:0]       key_out_q, key_out_d;
    logic              code_ready_q, code_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              accept;
    logic              timer_last;
    logic [11:0]       in_onehot;
    logic [11:0]       code_onehot;

    assign accept      = code_valid && code_ready_q;
    assign timer_last  = (timer_q == CNT_ONE);
    assign in_onehot   = 12'd1 << code_in;
    assign code_onehot = 12'd1 << code_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            code_q       <= '0;
            key_out_q    <= '0;
            code_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            code_q       <= code_d;
            key_out_q    <= key_out_d;
            code_ready_q <= code_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    // Each state loads its length on entry and leaves when the timer reads 1.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        code_d    = code_q;
        key_out_d = key_out_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            IDLE: begin
                key_out_d = '0;
                timer_d   = '0;
                if (accept) begin
                    if (code_in > 4'd11) begin
                        err_d = 1'b1;
                    end else begin
                        code_d    = code_in;
                        key_out_d = in_onehot;
                        if (HAS_BOUNCE) begin
                            state_d = BOUNCE_P;
                            timer_d = BOUNCE_LD;
                        end else begin
                            state_d = HOLD;
                            timer_d = HOLD_LD;
                        end
                    end
                end
            end
            BOUNCE_P: begin
                if (timer_last) begin
                    state_d   = HOLD;
                    timer_d   = HOLD_LD;
                    key_out_d = code_onehot;
                end else begin
                    timer_d   = timer_q - CNT_ONE;
                    key_out_d = key_out_q ^ code_onehot;
                end
            end
            HOLD: begin
                if (timer_last) begin
                    key_out_d = '0;
                    if (HAS_BOUNCE) begin
                        state_d = BOUNCE_R;
                        timer_d = BOUNCE_LD;
                    end else begin
                        state_d = GAP;
                        timer_d = GAP_LD;
                    end
                end else begin
                    timer_d = timer_q - CNT_ONE;
                end
            end
            BOUNCE_R: begin
                if (timer_last) begin
                    state_d   = GAP;
                    timer_d   = GAP_LD;
                    key_out_d = '0;
                end else begin
                    timer_d   = timer_q - CNT_ONE;
                    key_out_d = key_out_q ^ code_onehot;
                end
            end
            GAP: begin
                key_out_d = '0;
                if (timer_last) begin
                    state_d = IDLE;
                    timer_d = '0;
                    done_d  = 1'b1;
                end else begin
                    timer_d = timer_q - CNT_ONE;
                end
            end
            default: begin
                state_d   = IDLE;
                timer_d   = '0;
                key_out_d = '0;
            end
        endcase

        code_ready_d = (state_d == IDLE);
        busy_d       = (state_d != IDLE);
    end

    // Row r answers when any driven column of that row holds the asserted key.
    for (genvar gi = 0; gi < 4; gi++) begin : g_row
        assign Row[gi] = |(Col & key_out_q[3*gi +: 3]);
    end

    assign key_out    = key_out_q;
    assign code_ready = code_ready_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_keypad_emulator.sv
// Directed bench for keypad_emulator with default timing (HOLD=16, GAP=16, BOUNCE=4).
module tb_keypad_emulator;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  code_in = '0;
    logic        code_valid = 1'b0;
    logic        code_ready;
    logic [2:0]  Col = '0;
    logic [3:0]  Row;
    logic [11:0] key_out;
    logic        busy;
    logic        done;
    logic        err;

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;

    keypad_emulator dut (
        .clock      (clock),
        .reset      (reset),
        .code_in    (code_in),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .Col        (Col),
        .Row        (Row),
        .key_out    (key_out),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          n;
        logic [2:0]  col;
        logic [3:0]  row;
        logic [11:0] key;
        logic        busy;
        logic        done;
        logic        ready;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
            $display("ok   %s: got %0h", name, act);
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    // Offer a code on the current cycle; returns in cycle 1 after the accepting edge.
    task automatic press(input logic [3:0] code);
        code_in    = code;
        code_valid = 1'b1;
        cyc        = 0;
        step();
        code_valid = 1'b0;
    endtask

    initial begin
        // code 7 = row 2, col 1; Col=010 selects it, Row[2] answers
        vecs[0]  = '{1,  3'b010, 4'b0100, 12'h080, 1, 0, 0};
        vecs[1]  = '{2,  3'b010, 4'b0000, 12'h000, 1, 0, 0};
        vecs[2]  = '{3,  3'b010, 4'b0100, 12'h080, 1, 0, 0};
        vecs[3]  = '{4,  3'b010, 4'b0000, 12'h000, 1, 0, 0};
        vecs[4]  = '{5,  3'b010, 4'b0100, 12'h080, 1, 0, 0};
        vecs[5]  = '{10, 3'b001, 4'b0000, 12'h080, 1, 0, 0};
        vecs[6]  = '{10, 3'b010, 4'b0100, 12'h080, 1, 0, 0};
        vecs[7]  = '{11, 3'b011, 4'b0100, 12'h080, 1, 0, 0};
        vecs[8]  = '{12, 3'b000, 4'b0000, 12'h080, 1, 0, 0};
        vecs[9]  = '{13, 3'b101, 4'b0000, 12'h080, 1, 0, 0};
        vecs[10] = '{20, 3'b010, 4'b0100, 12'h080, 1, 0, 0};
        vecs[11] = '{21, 3'b010, 4'b0000, 12'h000, 1, 0, 0};
        vecs[12] = '{22, 3'b010, 4'b0100, 12'h080, 1, 0, 0};
        vecs[13] = '{23, 3'b010, 4'b0000, 12'h000, 1, 0, 0};
        vecs[14] = '{24, 3'b010, 4'b0100, 12'h080, 1, 0, 0};
        vecs[15] = '{25, 3'b010, 4'b0000, 12'h000, 1, 0, 0};
        vecs[16] = '{40, 3'b010, 4'b0000, 12'h000, 1, 0, 0};
        vecs[17] = '{41, 3'b010, 4'b0000, 12'h000, 0, 1, 1};
        vecs[18] = '{42, 3'b010, 4'b0000, 12'h000, 0, 0, 1};
        vecs[19] = '{43, 3'b111, 4'b0000, 12'h000, 0, 0, 1};

        // reset state
        Col = 3'b111;
        repeat (2) @(posedge clock);
        #1;
        check("rst key_out", key_out, 12'h000);
        check("rst Row", {8'h0, Row}, 12'h0);
        check("rst ready", {11'h0, code_ready}, 12'h0);
        check("rst busy", {11'h0, busy}, 12'h0);
        check("rst done_err", {10'h0, done, err}, 12'h0);
        #3 reset = 1'b1;
        step();
        check("ready after reset", {11'h0, code_ready}, 12'h1);

        // code 7 full sequence with Col changes during hold
        Col = 3'b010;
        press(4'd7);
        for (int i = 0; i < 20; i++) begin
            while (cyc < vecs[i].n) step();
            Col = vecs[i].col;
            #1;
            check($sformatf("seq7 n%0d row", vecs[i].n), {8'h0, Row}, {8'h0, vecs[i].row});
            check($sformatf("seq7 n%0d key", vecs[i].n), key_out, vecs[i].key);
            check($sformatf("seq7 n%0d flags", vecs[i].n), {9'h0, busy, done, code_ready},
                  {9'h0, vecs[i].busy, vecs[i].done, vecs[i].ready});
        end

        // illegal code 13
        press(4'd13);
        check("code13 err", {11'h0, err}, 12'h1);
        check("code13 key", key_out, 12'h000);
        check("code13 ready", {11'h0, code_ready}, 12'h1);
        check("code13 busy", {11'h0, busy}, 12'h0);
        step();
        check("code13 err pulse", {11'h0, err}, 12'h0);

        // back-to-back with code_valid held: 0 then 11
        Col = 3'b001;
        press(4'd0);
        code_valid = 1'b1;
        code_in    = 4'd11;
        check("b2b first key", key_out, 12'h001);
        check("b2b Row0", {8'h0, Row}, 12'h001);
        while (cyc < 20) step();
        check("b2b hold ignores valid", key_out, 12'h001);
        while (cyc < 40) step();
        check("b2b gap key", key_out, 12'h000);
        check("b2b gap ready", {11'h0, code_ready}, 12'h0);
        step();
        check("b2b done", {11'h0, done}, 12'h1);
        check("b2b done key", key_out, 12'h000);
        step();
        code_valid = 1'b0;
        check("b2b second key", key_out, 12'h800);
        check("b2b second busy", {11'h0, busy}, 12'h1);
        begin
            int budget = 60;
            while (!done && budget > 0) begin
                step();
                budget--;
            end
            check("b2b second done seen", {11'h0, done}, 12'h1);
        end

        // asynchronous reset during hold of code 5 (row 1, col 2)
        step();
        Col = 3'b100;
        press(4'd5);
        while (cyc < 10) step();
        check("rst5 hold key", key_out, 12'h020);
        check("rst5 hold Row", {8'h0, Row}, 12'h002);
        #2 reset = 1'b0;
        #1;
        check("rst5 async key", key_out, 12'h000);
        check("rst5 async Row", {8'h0, Row}, 12'h000);
        check("rst5 async busy", {11'h0, busy}, 12'h0);
        #10 reset = 1'b1;
        step();
        step();
        check("rst5 idle ready", {11'h0, code_ready}, 12'h1);
        check("rst5 idle busy", {11'h0, busy}, 12'h0);
        check("rst5 idle key", key_out, 12'h000);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/keypad_emulator.md
Name: keypad_emulator

Overview:
- Sequential model of a 3-column x 4-row keypad that answers a column scanner's Col drive with the Row response of a pressed key.
- Accepts one key code per handshake and replays it as a timed physical press: press bounce, hold, release bounce, then an inter-key gap.
- Used to drive the lock datapath from scripted key sequences, in benches and in on-board self-test, in place of the manual 12-bit Key vector.

Parameters:
HOLD_CYCLES, 16, cycles the key is held stable-pressed (>=1)
GAP_CYCLES, 16, cycles of stable release after a press before the next code is accepted (>=1)
BOUNCE_CYCLES, 4, cycles of bounce at press and at release (0 = no bounce)
CNT_W, 16, width of the internal timer; must hold max(HOLD_CYCLES, GAP_CYCLES, BOUNCE_CYCLES)

Ports:
clock       input   1   system clock, rising edge
reset       input   1   asynchronous, active-low reset
code_in     input   4   key code 0..11; key k sits at row k/3, column k%3
code_valid  input   1   code_in is valid this cycle
code_ready  output  1   block accepts a code this cycle
Col         input   3   scanner column drive, active-high, one-hot expected
Row         output  4   row response, active-high
key_out     output  12  one-hot image of the currently asserted key (bit k)
busy        output  1   a press sequence is in progress
done        output  1   1-cycle pulse when the GAP state completes
err         output  1   1-cycle pulse when code 12..15 is offered

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, key_out=0, Row=0, code_ready=0, busy=0, done=0, err=0, timer=0, stored code=0.
- Handshake: code_ready=1 only in IDLE. A transfer occurs on a rising edge with code_valid=1 and code_ready=1.
- Code 0..11: the code is latched and the block moves to BOUNCE_P, or directly to HOLD when BOUNCE_CYCLES=0.
- Code 12..15: err pulses on the next cycle, the block stays in IDLE, and no key is asserted.
- States and timing:
  - IDLE: key_out=0; waits for a transfer.
  - BOUNCE_P: BOUNCE_CYCLES cycles. key_out[code] toggles every cycle, starting asserted in the first cycle. Then HOLD.
  - HOLD: key_out[code]=1 for exactly HOLD_CYCLES cycles. Then BOUNCE_R, or GAP when BOUNCE_CYCLES=0.
  - BOUNCE_R: BOUNCE_CYCLES cycles. key_out[code] toggles every cycle, starting deasserted. Then GAP.
  - GAP: key_out=0 for GAP_CYCLES cycles. Then IDLE with done=1 in the first IDLE cycle.
- busy=1 in every state except IDLE. code_ready and busy are registered.
- Timer: loads at each state entry, counts down, and advances the state at 1. There is no wrap-around.
- Row is combinational from Col and registered key_out: Row[r] = OR over c of (Col[c] AND key_out[3r+c]).
  - A stable key answers the scanner in the same cycle Col changes.
  - Col=0 gives Row=0. A non-one-hot Col ORs the rows and is legal.
- code_valid held while busy: ignored, and not queued.
- Back-to-back: the first code can be accepted in the same cycle done is high.
- Reset mid-sequence clears key_out immediately and asynchronously; Row drops with it.

Test Plan:
1. Reset held low, then released, defaults HOLD=16, GAP=16, BOUNCE=4 -> all outputs 0 during reset; code_ready=1 on the first edge after release.
2. Offer code 7 (row 2, col 1) with Col=3'b010 -> bounce pattern on Row[2] for 4 cycles; Row=4'b0100 steady for 16 cycles; bounce for 4 cycles; 16 gap cycles; done pulse at cycle 41 after acceptance.
3. Same press with Col=3'b001 during HOLD -> Row=0; Col switched to 3'b010 mid-hold -> Row=4'b0100 in the same cycle.
4. Offer code 13 -> err=1 for one cycle, key_out=0, code_ready stays 1.
5. Keep code_valid=1 throughout with codes 0 then 11 -> second code accepted only in the done cycle; key_out goes 12'h001 then 12'h800 with a full gap between.
6. Assert reset during HOLD of code 5 -> key_out and Row become 0 without a clock edge; state is IDLE after release.
